// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST stimulus/compactor engine.
package bist_pkg;

  localparam int unsigned SIG_W = 8;
  localparam logic [SIG_W-1:0] POLY_DEFAULT = 8'h1D;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } bist_state_e;

endpackage

// File: rtl/bist_galois8.sv
// 8-bit Galois shift register with data injection; serves as both the
// pattern LFSR (din tied low) and the response MISR (din = CUT outputs).
module bist_galois8
  import bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY      = POLY_DEFAULT,
  parameter logic [SIG_W-1:0] RESET_VAL = '0
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             load,
  input  logic [SIG_W-1:0] load_val,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] q
);

  logic [SIG_W-1:0] q_q;
  logic [SIG_W-1:0] q_d;
  logic [SIG_W-1:0] shifted;

  always_comb begin
    shifted = {q_q[SIG_W-2:0], 1'b0} ^ (q_q[SIG_W-1] ? POLY : '0);
    q_d     = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = shifted ^ din;
    end
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bist_stim_compactor.sv
// BIST engine: LFSR stimulus to the CUT, MISR compaction of its outputs.
// Optional golden-signature compare enabled by BIST_GOLDEN_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for START, PI held at 0
// RUN    | applying NUM_PATTERNS vectors and compacting PO
// DONE   | signature final; START launches another run
module bist_stim_compactor
  import bist_pkg::*;
#(
  parameter int unsigned      NUM_PI       = 4,
  parameter int unsigned      NUM_PO       = 1,
  parameter int unsigned      NUM_PATTERNS = 64,
  parameter logic [SIG_W-1:0] LFSR_SEED    = 8'h01,
  parameter logic [SIG_W-1:0] POLY         = POLY_DEFAULT,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [NUM_PO-1:0] PO,
  output logic [NUM_PI-1:0] PI,
  output logic              BUSY,
  output logic              DONE,
  output logic [SIG_W-1:0]  SIGNATURE,
  output logic              PASS
);

  localparam int unsigned CNT_W = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);

  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("bist_stim_compactor: LFSR_SEED must be nonzero");
  end

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;
  logic             run_en;
  logic [SIG_W-1:0] lfsr_q;
  logic [SIG_W-1:0] misr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    run_en  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        run_en = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  bist_galois8 #(
    .POLY      (POLY),
    .RESET_VAL (LFSR_SEED)
  ) u_lfsr (
    .CK       (CK),
    .RSTN     (RSTN),
    .load     (load),
    .load_val (LFSR_SEED),
    .en       (run_en),
    .din      ('0),
    .q        (lfsr_q)
  );

  bist_galois8 #(
    .POLY      (POLY),
    .RESET_VAL ('0)
  ) u_misr (
    .CK       (CK),
    .RSTN     (RSTN),
    .load     (load),
    .load_val ('0),
    .en       (run_en),
    .din      (SIG_W'(PO)),
    .q        (misr_q)
  );

  // Outputs decode only registered state, so START/PO never reach them combinationally.
  assign BUSY      = (state_q == S_RUN);
  assign DONE      = (state_q == S_DONE);
  assign PI        = BUSY ? lfsr_q[NUM_PI-1:0] : '0;
  assign SIGNATURE = misr_q;

`ifdef BIST_GOLDEN_CHECK_EN
  assign PASS = DONE && (misr_q == GOLDEN_SIG);
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q;
`else
  assign PASS = 1'b0;
  logic unused_lfsr;
  assign unused_lfsr = ^{lfsr_q, GOLDEN_SIG};
`endif

endmodule
